bullet: RTL and testbench

//  Projectile engine for one player, sitting directly downstream of that player's tank.
//  - Consumes the tank's bullet_fire pulse, bullet_direction and tank position.
//  - Flies one 32-px map cell per game tick, queries the map ROM for walls and detects a hit
//    on the opposing tank; bullet_hit drives the opponent tank's killed input.
//  - Publishes a packed 32-bit object state for the OAM/renderer, same format as tank_state.

---
 rtl/bullet.sv | 182 ++++++++++++++++++
 tb/tb_bullet.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet.sv
// Single-player projectile: launched from the owning tank, advances one map cell per game
// tick, stops on walls, map edges or range expiry, and pulses bullet_hit when it reaches the opponent.
module bullet #(
  parameter int OWNER_INDEX = 0,
  parameter int MAX_RANGE   = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        game_over,
  input  logic        tick,
  input  logic        bullet_fire,
  input  logic [1:0]  bullet_direction,
  input  logic [9:0]  tank_x,
  input  logic [9:0]  tank_y,
  input  logic [9:0]  target_x,
  input  logic [9:0]  target_y,
  input  logic        target_active,
  input  logic        map_wall,
  output logic [3:0]  map_qx,
  output logic [3:0]  map_qy,
  output logic        busy,
  output logic        bullet_hit,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic [31:0] bullet_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_HITCHK = 2'd2,
    S_FLY    = 2'd3
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [3:0] RANGE_LIMIT = 4'(MAX_RANGE);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cell_x;
  logic [3:0] r_cell_y;
  logic [1:0] r_dir;
  logic [3:0] r_range;
  logic       r_hit;
  logic [3:0] r_qx;
  logic [3:0] r_qy;

  logic [3:0] w_nxt_x;
  logic [3:0] w_nxt_y;
  logic       w_boundary;
  logic [3:0] w_tgt_x;
  logic [3:0] w_tgt_y;
  logic       w_on_target;
  logic       w_nxt_on_target;
  logic       w_unused_bits;

  assign w_tgt_x = target_x[8:5];
  assign w_tgt_y = target_y[8:5];
  assign w_unused_bits = &{tank_x[9], tank_x[4:0], tank_y[9], tank_y[4:0],
                           target_x[9], target_x[4:0], target_y[9], target_y[4:0]};

  // Neighbouring cell in the flight direction, plus whether that step leaves the map
  always_comb begin
    w_nxt_x    = r_cell_x;
    w_nxt_y    = r_cell_y;
    w_boundary = 1'b0;
    case (r_dir)
      DIR_UP: begin
        w_nxt_y    = r_cell_y - 4'd1;
        w_boundary = (r_cell_y == 4'd0);
      end
      DIR_DOWN: begin
        w_nxt_y    = r_cell_y + 4'd1;
        w_boundary = (r_cell_y == 4'd15);
      end
      DIR_LEFT: begin
        w_nxt_x    = r_cell_x - 4'd1;
        w_boundary = (r_cell_x == 4'd0);
      end
      default: begin
        w_nxt_x    = r_cell_x + 4'd1;
        w_boundary = (r_cell_x == 4'd15);
      end
    endcase
  end

  assign w_on_target     = target_active && (r_cell_x == w_tgt_x) && (r_cell_y == w_tgt_y);
  assign w_nxt_on_target = target_active && (w_nxt_x == w_tgt_x) && (w_nxt_y == w_tgt_y);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // HITCHK reuses the hit registered on the step into it so the pulse and exit agree
  always_comb begin
    w_state_next = r_state;
    if (!game_over) begin
      case (r_state)
        S_IDLE: begin
          if (bullet_fire) w_state_next = S_STEP;
        end
        S_STEP: begin
          if (w_boundary || map_wall) w_state_next = S_IDLE;
          else                        w_state_next = S_HITCHK;
        end
        S_HITCHK: begin
          if (r_hit || (r_range == RANGE_LIMIT)) w_state_next = S_IDLE;
          else                                   w_state_next = S_FLY;
        end
        default: begin
          if (w_on_target) w_state_next = S_IDLE;
          else if (tick)   w_state_next = S_STEP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cell_x <= 4'd0;
      r_cell_y <= 4'd0;
      r_dir    <= 2'd0;
      r_range  <= 4'd0;
      r_hit    <= 1'b0;
      r_qx     <= 4'd0;
      r_qy     <= 4'd0;
    end else if (!game_over) begin
      r_hit <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bullet_fire) begin
            r_dir    <= bullet_direction;
            r_cell_x <= tank_x[8:5];
            r_cell_y <= tank_y[8:5];
            r_range  <= 4'd0;
          end
        end
        S_STEP: begin
          if (!w_boundary) begin
            r_qx <= w_nxt_x;
            r_qy <= w_nxt_y;
            if (!map_wall) begin
              r_cell_x <= w_nxt_x;
              r_cell_y <= w_nxt_y;
              r_range  <= r_range + 4'd1;
              r_hit    <= w_nxt_on_target;
            end
          end
        end
        S_FLY: begin
          r_hit <= w_on_target;
        end
        default: begin
        end
      endcase
    end
  end

  // The query address is live only while stepping; otherwise the last query is held
  always_comb begin
    map_qx = r_qx;
    map_qy = r_qy;
    if ((r_state == S_STEP) && !w_boundary) begin
      map_qx = w_nxt_x;
      map_qy = w_nxt_y;
    end
    busy         = (r_state != S_IDLE);
    bullet_hit   = r_hit && !game_over;
    pos_x        = {1'b0, r_cell_x, 5'b0};
    pos_y        = {1'b0, r_cell_y, 5'b0};
    bullet_state = {1'b1, 2'(OWNER_INDEX), busy, pos_x, pos_y, r_dir, 3'b001, 1'b0, r_dir};
  end

endmodule

// File: tb/tb_bullet.sv
// Directed bench for bullet: flight-end records are queued at fire time and checked by a
// negedge monitor; latency and hold behaviour are checked inline.
module tb_bullet;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       game_over = 1'b0;
  logic       tick = 1'b0;
  logic       fire0 = 1'b0;
  logic       fire1 = 1'b0;
  logic [1:0] dir = 2'd0;
  logic [9:0] tank_x = 10'd0;
  logic [9:0] tank_y = 10'd0;
  logic [9:0] target_x = 10'd0;
  logic [9:0] target_y = 10'd0;
  logic       target_active = 1'b0;
  logic       map_bits [0:15][0:15];

  logic [3:0]  qx0, qy0, qx1, qy1;
  logic        busy0, busy1, hit0, hit1, wall0, wall1;
  logic [9:0]  px0, py0, px1, py1;
  logic [31:0] st0, st1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int hit;
    int x;
    int y;
  } exp_t;

  exp_t exp0[$];
  exp_t exp1[$];

  always #5 clk = ~clk;

  assign wall0 = map_bits[qy0][qx0];
  assign wall1 = map_bits[qy1][qx1];

  bullet #(.OWNER_INDEX(0), .MAX_RANGE(15)) u_dut (
    .clk(clk), .reset_n(reset_n), .game_over(game_over), .tick(tick),
    .bullet_fire(fire0), .bullet_direction(dir), .tank_x(tank_x), .tank_y(tank_y),
    .target_x(target_x), .target_y(target_y), .target_active(target_active),
    .map_wall(wall0), .map_qx(qx0), .map_qy(qy0), .busy(busy0), .bullet_hit(hit0),
    .pos_x(px0), .pos_y(py0), .bullet_state(st0)
  );

  bullet #(.OWNER_INDEX(1), .MAX_RANGE(2)) u_short (
    .clk(clk), .reset_n(reset_n), .game_over(game_over), .tick(tick),
    .bullet_fire(fire1), .bullet_direction(dir), .tank_x(tank_x), .tank_y(tank_y),
    .target_x(target_x), .target_y(target_y), .target_active(target_active),
    .map_wall(wall1), .map_qx(qx1), .map_qy(qy1), .busy(busy1), .bullet_hit(hit1),
    .pos_x(px1), .pos_y(py1), .bullet_state(st1)
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: counts hit pulses per flight and scores each flight end against the queue
  logic pbusy [0:1] = '{1'b0, 1'b0};
  int   hcnt  [0:1] = '{0, 0};

  always @(negedge clk) begin
    logic b;
    logic h;
    int   x;
    int   y;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      b = (d == 0) ? busy0 : busy1;
      h = (d == 0) ? hit0 : hit1;
      x = (d == 0) ? int'(px0) : int'(px1);
      y = (d == 0) ? int'(py0) : int'(py1);
      if (h) hcnt[d]++;
      if (pbusy[d] && !b) begin
        if ((d == 0) ? (exp0.size() == 0) : (exp1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL dut%0d_unexpected_end: actual=flight end required=no flight end", d);
        end else begin
          e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
          check($sformatf("dut%0d_hits", d), hcnt[d], e.hit);
          check($sformatf("dut%0d_end_x", d), x, e.x);
          check($sformatf("dut%0d_end_y", d), y, e.y);
          $display("flight end dut%0d pos=(%0d,%0d) hits=%0d", d, x, y, hcnt[d]);
        end
        hcnt[d] = 0;
      end
      pbusy[d] = b;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input int d, input logic [9:0] x, input logic [9:0] y, input logic [1:0] dr);
    tank_x = x;
    tank_y = y;
    dir    = dr;
    if (d == 0) fire0 = 1'b1;
    else        fire1 = 1'b1;
    cyc();
    fire0 = 1'b0;
    fire1 = 1'b0;
  endtask

  // Ticks every fourth cycle until the chosen bullet lands, bounded by budget
  task automatic run_to_idle(input int d, input int budget);
    int done = 0;
    for (int n = 0; n < budget; n++) begin
      tick = (n % 4 == 0);
      cyc();
      tick = 1'b0;
      @(negedge clk);
      if (((d == 0) ? busy0 : busy1) == 1'b0) begin
        done = 1;
        break;
      end
    end
    tick = 1'b0;
    check($sformatf("dut%0d_idle_within_budget", d), done, 1);
  endtask

  initial begin
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        map_bits[y][x] = 1'b0;

    repeat (3) cyc();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_hit", hit0, 0);
    check("rst_pos_x", px0, 0);
    check("rst_pos_y", py0, 0);
    check("rst_qx", qx0, 0);
    check("rst_qy", qy0, 0);
    check("rst_state", st0, 32'h8000_0008);
    check("rst_busy_short", busy1, 0);

    // First step east from (64,64), then a wall at (4,2)
    cyc();
    exp0.push_back('{0, 96, 64});
    fire(0, 10'd64, 10'd64, 2'b11);
    @(negedge clk);
    check("step1_qx", qx0, 3);
    check("step1_qy", qy0, 2);
    check("step1_busy", busy0, 1);
    cyc();
    @(negedge clk);
    check("step1_pos_x", px0, 96);
    check("step1_pos_y", py0, 64);
    check("step1_state", st0, 32'h9180_40CB);
    cyc();
    fire(0, 10'd0, 10'd0, 2'b00);
    @(negedge clk);
    check("refire_busy", busy0, 1);
    check("refire_pos_x", px0, 96);
    check("refire_qx", qx0, 3);
    map_bits[2][4] = 1'b1;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    @(negedge clk);
    check("wall_qx", qx0, 4);
    check("wall_qy", qy0, 2);
    cyc();
    @(negedge clk);
    check("wall_busy", busy0, 0);
    check("wall_pos_x", px0, 96);
    repeat (3) cyc();
    @(negedge clk);
    check("refire_not_queued", busy0, 0);
    map_bits[2][4] = 1'b0;

    // Target at cell (5,2), struck on the third step
    cyc();
    target_x = 10'd160;
    target_y = 10'd64;
    target_active = 1'b1;
    exp0.push_back('{1, 160, 64});
    fire(0, 10'd64, 10'd64, 2'b11);
    run_to_idle(0, 60);
    target_active = 1'b0;

    // Spawn on the top row heading up: exits at once, query held at (5,2)
    cyc();
    exp0.push_back('{0, 64, 0});
    fire(0, 10'd64, 10'd0, 2'b00);
    @(negedge clk);
    check("edge_busy", busy0, 1);
    check("edge_qx_held", qx0, 5);
    check("edge_qy_held", qy0, 2);
    cyc();
    @(negedge clk);
    check("edge_busy_after", busy0, 0);

    // Two-step range expiry on the short-range instance
    cyc();
    exp1.push_back('{0, 128, 64});
    fire(1, 10'd64, 10'd64, 2'b11);
    run_to_idle(1, 60);

    // Freeze during flight heading south, then fly to the bottom edge
    cyc();
    exp0.push_back('{0, 64, 480});
    fire(0, 10'd64, 10'd64, 2'b01);
    @(negedge clk);
    check("south_qx", qx0, 2);
    check("south_qy", qy0, 3);
    cyc();
    cyc();
    game_over = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick = (i % 2 == 0);
      cyc();
    end
    tick = 1'b0;
    @(negedge clk);
    check("frozen_pos_y", py0, 96);
    check("frozen_busy", busy0, 1);
    check("frozen_qy", qy0, 3);
    cyc();
    game_over = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    check("pending_tick_lost", py0, 96);
    run_to_idle(0, 100);

    // Target appears under a frozen bullet; hit only once game_over clears
    cyc();
    exp0.push_back('{1, 96, 64});
    fire(0, 10'd64, 10'd64, 2'b11);
    cyc();
    cyc();
    game_over = 1'b1;
    target_x = 10'd96;
    target_y = 10'd64;
    target_active = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    check("gated_hit", hit0, 0);
    check("gated_busy", busy0, 1);
    cyc();
    game_over = 1'b0;
    cyc();
    @(negedge clk);
    check("fly_hit_busy", busy0, 0);
    check("fly_hit_pulse", hit0, 1);
    cyc();
    @(negedge clk);
    check("fly_hit_one_cycle", hit0, 0);
    target_active = 1'b0;

    // Asynchronous reset mid-flight
    cyc();
    exp0.push_back('{0, 0, 0});
    fire(0, 10'd64, 10'd64, 2'b11);
    cyc();
    cyc();
    #1;
    reset_n = 1'b0;
    #1;
    check("async_busy", busy0, 0);
    check("async_hit", hit0, 0);
    check("async_pos_x", px0, 0);
    check("async_pos_y", py0, 0);
    check("async_qx", qx0, 0);
    check("async_qy", qy0, 0);
    @(negedge clk);
    cyc();
    reset_n = 1'b1;

    repeat (2) cyc();
    @(negedge clk);
    check("dut0_queue_empty", exp0.size(), 0);
    check("dut1_queue_empty", exp1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
